reg_bank_arbiter: RTL and testbench

Shares the single register bank port (address, data_in, rw, data_out) among NUM_REQ requesters, e.g. CPU-side bus, DMA and test sequencer.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences each access: issue, read-latency wait, response.
- Sits between the requester fabric and the reg bank, driving the reg bank interface signals directly.

---
 rtl/reg_bank_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares one register bank port among NUM_REQ requesters, one access in flight.
// Latency: accept pulse at T, bank issue at T+1, response at T+2 (write) or T+2+RD_LAT (read).
// Backpressure: requesters hold req_valid_i until their req_ready_o pulse; no sampling while busy.
// Build option: define REG_BANK_ARB_FIXED_PRIO_EN for fixed lowest-index-first arbitration.
//
// Every output is a register loaded from the FSM state of the previous cycle, so the bank sees an
// access one cycle after the ISSUE state, and read data is captured during the DONE state, which is
// exactly RD_LAT cycles after the address reached the bank.
module reg_bank_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int RD_LAT  = 1
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ-1:0]        req_rw_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic [ADDR_W-1:0]         bank_address_o,
   output logic [DATA_W-1:0]         bank_data_in_o,
   output logic                      bank_rw_o,
   input  logic [DATA_W-1:0]         bank_data_out_i,
   output logic                      busy_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 3;
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   // latched request of the transaction in flight
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // arbitration result for the current cycle
   logic              grant_vld;
   logic [IDX_W-1:0]  grant_idx;

   // output registers
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_W-1:0]  bank_address_q, bank_address_d;
   logic [DATA_W-1:0]  bank_data_in_q, bank_data_in_d;
   logic               bank_rw_q, bank_rw_d;
   logic               busy_q, busy_d;

`ifdef REG_BANK_ARB_FIXED_PRIO_EN
   // Fixed priority: the lowest-index pending requester wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [IDX_W-1:0] cand_idx;
   int               cand;

   // Round robin: scan from last_grant+1 upward with wrap; the closest pending requester wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = int'(last_grant_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (req_valid_i[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // Pointer moves only when a grant is issued from IDLE.
   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == S_IDLE && grant_vld) begin
         last_grant_d = grant_idx;
      end
   end

   // Round-robin pointer register; reset gives requester 0 top priority.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_grant_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (grant_vld) state_d = S_ISSUE;
         S_ISSUE: state_d = (rw_q || RD_LAT == 0) ? S_DONE : S_WAIT;
         S_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch and read-latency counter next state.
   always_comb begin
      idx_d   = idx_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               idx_d   = grant_idx;
               rw_d    = req_rw_i[grant_idx];
               addr_d  = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
               wdata_d = req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
            end
         end
         S_ISSUE: cnt_d = CNT_W'(RD_LAT);
         S_WAIT:  cnt_d = cnt_q - CNT_W'(1);
         default: ;
      endcase
   end

   // Request latch and counter registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idx_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM outputs: bank_rw is parked low except after ISSUE of a write; address held between issues.
   always_comb begin
      req_ready_d    = '0;
      rsp_valid_d    = '0;
      rsp_rdata_d    = '0;
      bank_rw_d      = 1'b0;
      bank_address_d = bank_address_q;
      bank_data_in_d = bank_data_in_q;
      busy_d         = (state_d != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (grant_vld) req_ready_d = ONE << grant_idx;
         end
         S_ISSUE: begin
            bank_rw_d      = rw_q;
            bank_address_d = addr_q;
            bank_data_in_d = wdata_q;
         end
         S_DONE: begin
            rsp_valid_d = ONE << idx_q;
            if (!rw_q) rsp_rdata_d = bank_data_out_i;
         end
         default: ;
      endcase
   end

   // Output registers; reset forces every output, including bank_rw, low at once.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         req_ready_q    <= '0;
         rsp_valid_q    <= '0;
         rsp_rdata_q    <= '0;
         bank_address_q <= '0;
         bank_data_in_q <= '0;
         bank_rw_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         req_ready_q    <= req_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         bank_address_q <= bank_address_d;
         bank_data_in_q <= bank_data_in_d;
         bank_rw_q      <= bank_rw_d;
         busy_q         <= busy_d;
      end
   end

   assign req_ready_o    = req_ready_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rdata_o    = rsp_rdata_q;
   assign bank_address_o = bank_address_q;
   assign bank_data_in_o = bank_data_in_q;
   assign bank_rw_o      = bank_rw_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed vector table, mid-read reset, then random traffic for reg_bank_arbiter.
// A transaction-level reference model predicts grants, bank accesses and responses cycle by cycle.
// A simple register bank with RD_LAT read latency sits on the bank port.
module tb_reg_bank_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int RD_LAT  = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid, req_rw;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready, rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata, bank_data_in, bank_dout;
   logic [ADDR_W-1:0]         bank_address;
   logic                      bank_rw, busy;

   reg_bank_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk_i(clk), .reset_ni(rst_n),
      .req_valid_i(req_valid), .req_rw_i(req_rw), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .bank_address_o(bank_address), .bank_data_in_o(bank_data_in), .bank_rw_o(bank_rw),
      .bank_data_out_i(bank_dout), .busy_o(busy)
   );

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return {~a, a};
   endfunction

   // register bank environment
   logic        bank_init;
   logic [15:0] bank_mem [256];
   logic [15:0] rd_pipe [8];
   always @(posedge clk) begin
      if (bank_init) begin
         for (int a = 0; a < 256; a++) bank_mem[a] <= init_val(8'(a));
      end else if (bank_rw) begin
         bank_mem[bank_address] <= bank_data_in;
      end
      rd_pipe[0] <= bank_mem[bank_address];
      for (int k = 1; k < 8; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bank_dout = (RD_LAT == 0) ? bank_mem[bank_address] : rd_pipe[(RD_LAT == 0) ? 0 : RD_LAT-1];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   // reference model state
   logic [15:0] mem_m [256];
   bit          in_reset;
   int          last_m, idle_from;
   bit          t_act, t_rw;
   int          t_idx, t_ready, t_rsp;
   logic [7:0]  t_addr;
   logic [15:0] t_wdata;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
      end
   endtask

   // arbitration rule: first pending requester after the last grant, wrapping
   function automatic int pick(input logic [NUM_REQ-1:0] v);
      int r;
      r = -1;
`ifdef REG_BANK_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NUM_REQ; k++) if (r < 0 && v[k]) r = k;
`else
      for (int k = 1; k <= NUM_REQ; k++) if (r < 0 && v[(last_m + k) % NUM_REQ]) r = (last_m + k) % NUM_REQ;
`endif
      return r;
   endfunction

   task automatic model_reset();
      in_reset  = 1'b1;
      t_act     = 1'b0;
      last_m    = NUM_REQ - 1;
      idle_from = 1 << 30;
   endtask

   // advance one cycle, compare every output at the falling edge
   task automatic tick();
      logic [NUM_REQ-1:0] e_rdy, e_rspv;
      logic [15:0]        e_rdata;
      logic               e_rw, e_busy;
      int                 w;
      @(negedge clk);
      cyc++;
      e_rdy = '0; e_rspv = '0; e_rdata = '0; e_rw = 1'b0; e_busy = 1'b0;
      if (!in_reset) begin
         if (t_act) begin
            if (cyc == t_ready + 1) begin
               e_rw = t_rw;
               chk("issue_addr", 64'(bank_address), 64'(t_addr));
               if (t_rw) begin
                  chk("issue_wdata", 64'(bank_data_in), 64'(t_wdata));
                  mem_m[t_addr] = t_wdata;
               end
            end else if (!t_rw && cyc > t_ready + 1 && cyc < t_rsp) begin
               chk("wait_addr_hold", 64'(bank_address), 64'(t_addr));
            end
            if (cyc == t_rsp) begin
               e_rspv  = NUM_REQ'(1) << t_idx;
               e_rdata = t_rw ? 16'h0 : mem_m[t_addr];
               t_act   = 1'b0;
            end
         end
         if (cyc - 1 >= idle_from && req_valid != '0) begin
            w         = pick(req_valid);
            e_rdy     = NUM_REQ'(1) << w;
            t_act     = 1'b1;
            t_idx     = w;
            t_rw      = req_rw[w];
            t_addr    = req_addr[w*ADDR_W +: ADDR_W];
            t_wdata   = req_wdata[w*DATA_W +: DATA_W];
            t_ready   = cyc;
            t_rsp     = cyc + 2 + (t_rw ? 0 : RD_LAT);
            idle_from = t_rsp;
            last_m    = w;
         end
         e_busy = t_act && cyc >= t_ready && cyc < t_rsp;
      end
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rspv));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      chk("bank_rw", 64'(bank_rw), 64'(e_rw));
      chk("busy", 64'(busy), 64'(e_busy));
   endtask

   typedef struct {
      logic [NUM_REQ-1:0] mask;
      logic [NUM_REQ-1:0] rw;
      logic [7:0]         abase;
      logic [15:0]        wbase;
      int                 winner;
      logic [15:0]        rdata;
      int                 lat;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] m, input logic [3:0] rw, input logic [7:0] ab,
                               input logic [15:0] wb, input int w, input logic [15:0] rd, input int lat);
      vec_t v;
      v.mask = m; v.rw = rw; v.abase = ab; v.wbase = wb; v.winner = w; v.rdata = rd; v.lat = lat;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[$];
      int   n, gcyc, prev_rsp;

      // expectations: requester i uses addr abase+i and wdata wbase+i; bank preload is {~a, a}
      vt.push_back(mk(4'b0001, 4'b0001, 8'h10, 16'hBEEF, 0, 16'h0000, 2));
      vt.push_back(mk(4'b0100, 4'b0000, 8'h0E, 16'h0000, 2, 16'hBEEF, 2 + RD_LAT));
`ifdef REG_BANK_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++) vt.push_back(mk(4'b1001, 4'b0000, 8'h20, 16'h0, 0, 16'hDF20, 2 + RD_LAT));
      vt.push_back(mk(4'b1000, 4'b0000, 8'h20, 16'h0, 3, 16'hDC23, 2 + RD_LAT));
`else
      vt.push_back(mk(4'b1000, 4'b0000, 8'h30, 16'h0, 3, 16'hCC33, 2 + RD_LAT));
      vt.push_back(mk(4'b1111, 4'b0000, 8'h20, 16'h0, 0, 16'hDF20, 2 + RD_LAT));
      vt.push_back(mk(4'b1111, 4'b0000, 8'h20, 16'h0, 1, 16'hDE21, 2 + RD_LAT));
      vt.push_back(mk(4'b1111, 4'b0000, 8'h20, 16'h0, 2, 16'hDD22, 2 + RD_LAT));
      vt.push_back(mk(4'b1111, 4'b0000, 8'h20, 16'h0, 3, 16'hDC23, 2 + RD_LAT));
      vt.push_back(mk(4'b1111, 4'b0000, 8'h20, 16'h0, 0, 16'hDF20, 2 + RD_LAT));
      vt.push_back(mk(4'b1111, 4'b0000, 8'h20, 16'h0, 1, 16'hDE21, 2 + RD_LAT));
      vt.push_back(mk(4'b1000, 4'b1000, 8'h50, 16'h1234, 3, 16'h0000, 2));
      vt.push_back(mk(4'b1010, 4'b0000, 8'h40, 16'h0, 1, 16'hBE41, 2 + RD_LAT));
      vt.push_back(mk(4'b1000, 4'b0000, 8'h40, 16'h0, 3, 16'hBC43, 2 + RD_LAT));
`endif

      for (int a = 0; a < 256; a++) mem_m[a] = init_val(8'(a));
      rst_n = 1'b1; bank_init = 1'b1;
      req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) tick();
      bank_init = 1'b0;
      chk("reset_state", 64'({req_ready, rsp_valid, rsp_rdata, bank_address, bank_data_in, bank_rw, busy}), 64'(0));
      rst_n = 1'b1; in_reset = 1'b0; idle_from = cyc;

      // directed vectors
      prev_rsp = cyc;
      foreach (vt[e]) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = vt[e].mask[i];
            req_rw[i] = vt[e].rw[i];
            req_addr[i*ADDR_W +: ADDR_W] = vt[e].abase + 8'(i);
            req_wdata[i*DATA_W +: DATA_W] = vt[e].wbase + 16'(i);
         end
         n = 0;
         do begin tick(); n++; end while (req_ready == '0 && n < 20);
         chk("vec_grant", 64'(req_ready), 64'(NUM_REQ'(1) << vt[e].winner));
         if (e > 0) chk("vec_gap", 64'(cyc - prev_rsp), 64'(1));
         gcyc = cyc;
         req_valid = req_valid & ~req_ready;
         n = 0;
         do begin tick(); n++; end while (rsp_valid == '0 && n < 20);
         chk("vec_latency", 64'(cyc - gcyc), 64'(vt[e].lat));
         chk("vec_rdata", 64'(rsp_rdata), 64'(vt[e].rdata));
         prev_rsp = cyc;
      end
      req_valid = '0;
      repeat (2) tick();

      // reset while a read is waiting on the bank
      req_valid = 4'b0100; req_rw = '0; req_addr[2*ADDR_W +: ADDR_W] = 8'h10;
      n = 0;
      do begin tick(); n++; end while (req_ready == '0 && n < 20);
      chk("rst_seq_grant", 64'(req_ready), 64'(4'b0100));
      req_valid = '0;
      tick();
      #1 rst_n = 1'b0;
      model_reset();
      #1 chk("rst_async_outputs", 64'({req_ready, rsp_valid, rsp_rdata, bank_address, bank_data_in, bank_rw, busy}), 64'(0));
      req_valid = 4'b0111;
      for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 8'(i);
      repeat (3) tick();
      rst_n = 1'b1; in_reset = 1'b0; idle_from = cyc;
      n = 0;
      do begin tick(); n++; end while (req_ready == '0 && n < 20);
      chk("rst_next_grant", 64'(req_ready), 64'(4'b0001));
      req_valid = '0;
      repeat (6) tick();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
               if ($urandom_range(31) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               req_valid[i] = 1'b1;
               req_rw[i] = 1'($urandom_range(1));
               req_addr[i*ADDR_W +: ADDR_W] = 8'($urandom_range(15));
               req_wdata[i*DATA_W +: DATA_W] = 16'($urandom);
            end
         end
      end
      req_valid = '0;
      repeat (12) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
